arp_request_gen: RTL and testbench
==================================

// Module: arp_request_gen
// PURPOSE
//  ARP initiator that complements arp_reply. On a request it emits one ARP who-has frame (60 B,
//  single 512-bit beat) on m_axis, then watches s_axis for the matching ARP reply.
//  It returns the resolved MAC, or a failure after a bounded number of timed-out retries.
//  Sits between the host/control logic and the NetFPGA-style AXIS datapath.
// PARAMETERS
//  AXIS_DATA_WIDTH   512                   tdata width; fixed, since the frame is one beat
//  AXIS_TUSER_WIDTH  256                   tuser width
//  MAC_ADDR          48'hDA_02_03_04_05_00 own MAC: SHA and Ethernet source
//  IP_ADDR           32'hC0_A8_01_0A       own IP: SPA; also the required TPA of replies
//  DST_PORT          8'h01                 one-hot output port placed in tuser[31:24]
//  TIMEOUT_CYCLES    200000                wait per attempt (1 ms at 200 MHz)
//  MAX_RETRIES       3                     retransmits after the first attempt
//  TIMER_WIDTH       24                    timeout counter width; must hold TIMEOUT_CYCLES
// PORTS
//  axis_aclk      in   1      clock
//  axis_reset     in   1      synchronous reset, active-high
//  req_valid      in   1      resolve request
//  req_ready      out  1      high only in IDLE
//  req_ip         in   32     target IP, sampled on req_valid&req_ready
//  rsp_valid      out  1      one-cycle result pulse
//  rsp_fail       out  1      qualifies rsp_valid: 1 = all attempts timed out
//  rsp_ip         out  32     target IP of this result
//  rsp_mac        out  48     resolved MAC; 0 when rsp_fail
//  m_axis_tdata   out  512    request frame
//  m_axis_tkeep   out  64     byte enables
//  m_axis_tuser   out  256    metadata
//  m_axis_tvalid  out  1      frame valid
//  m_axis_tready  in   1      downstream ready
//  m_axis_tlast   out  1      end of frame
//  s_axis_tdata   in   512    received frames
//  s_axis_tkeep   in   64     byte enables (ignored)
//  s_axis_tuser   in   256    metadata (ignored)
//  s_axis_tvalid  in   1      receive valid
//  s_axis_tready  out  1      tied 1; pure sink, no backpressure
//  s_axis_tlast   in   1      end of received frame
// BEHAVIOUR
//  Byte order: frame byte i is on tdata[8i+7:8i]. Multi-byte fields are big-endian on the wire,
//  so MAC_ADDR[47:40] is the first byte of its field.
//  TX frame bytes:
//   0-5 FF; 6-11 MAC_ADDR; 12-13 0806; 14-15 0001; 16-17 0800; 18 06; 19 04; 20-21 0001;
//   22-27 MAC_ADDR; 28-31 IP_ADDR; 32-37 00; 38-41 target IP; 42-63 00.
//  TX sideband: tkeep=64'h0FFF_FFFF_FFFF_FFFF; tlast=1; tuser[15:0]=16'd60,
//   tuser[31:24]=DST_PORT, all other tuser bits 0.
//  FSM: IDLE -> SEND -> WAIT -> IDLE.
//   IDLE: accept request; latch target; retry count=0; go to SEND.
//   SEND: tvalid=1, all m_axis outputs held stable until tready.
//     On the handshake: timer=0, go to WAIT.
//   WAIT: timer increments every cycle. Inspect the first beat of each s_axis frame only;
//     track start-of-frame from tlast. The beat matches when all hold:
//     bytes 12-13==0806, bytes 20-21==0002, SPA (28-31)==target, TPA (38-41)==IP_ADDR.
//     On match: capture SHA (bytes 22-27); rsp_valid=1, rsp_fail=0 the next cycle; go to IDLE.
//     On timer==TIMEOUT_CYCLES-1 with no match:
//       retry count<MAX_RETRIES -> increment retry count, go to SEND;
//       otherwise -> rsp_valid=1, rsp_fail=1, rsp_mac=0; go to IDLE.
//  Latency: first request frame appears 1 cycle after the req handshake.
//   Result appears 1 cycle after the matching beat.
//  A match and a timeout in the same cycle: the match wins.
//  s_axis beats seen outside WAIT, and non-first beats, are dropped.
//  Frame-start tracking keeps running in every state.
//  Reset values: all outputs 0 except s_axis_tready=1; req_ready=1 from the first cycle after
//   reset. Reset mid-SEND drops tvalid immediately, with no handshake required.
// TESTING
//  1 req_ip=C0A8010B into arp_reply (IP_ADDR_1) -> one frame with bytes 38-41=C0A8010B;
//    rsp_valid, rsp_fail=0, rsp_mac=DA0203040501.
//  2 No reply, TIMEOUT_CYCLES=100, MAX_RETRIES=2 -> 3 frames spaced 100 cycles after each
//    handshake; then rsp_fail=1, rsp_mac=0.
//  3 Replies with SPA=C0A8010C, or oper=0001, or TPA!=IP_ADDR -> ignored; times out as in 2.
//  4 m_axis_tready low for 10 cycles -> tdata/tkeep/tuser/tlast stable; exactly one beat accepted.
//  5 Matching reply on the cycle timer==TIMEOUT_CYCLES-1 -> success, no retransmit.
//  6 axis_reset during WAIT, then new req C0A8010D -> no stale rsp_valid; resolves DA0203040503.

Source files
------------

// File: rtl/arp_request_gen.sv
// ARP initiator: sends a single-beat who-has frame, waits for the matching reply,
// and retransmits on timeout until the retry budget is exhausted.
module arp_request_gen #(
    parameter int unsigned AXIS_DATA_WIDTH  = 512,
    parameter int unsigned AXIS_TUSER_WIDTH = 256,
    parameter logic [47:0] MAC_ADDR         = 48'hDA_02_03_04_05_00,
    parameter logic [31:0] IP_ADDR          = 32'hC0_A8_01_0A,
    parameter logic [7:0]  DST_PORT         = 8'h01,
    parameter int unsigned TIMEOUT_CYCLES   = 200000,
    parameter int unsigned MAX_RETRIES      = 3,
    parameter int unsigned TIMER_WIDTH      = 24
) (
    input  logic                          axis_aclk,
    input  logic                          axis_reset,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [31:0]                   req_ip,
    output logic                          rsp_valid,
    output logic                          rsp_fail,
    output logic [31:0]                   rsp_ip,
    output logic [47:0]                   rsp_mac,
    output logic [AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic [AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    input  logic [AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic                          s_axis_tlast
);

    localparam int unsigned RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam logic [RETRY_W-1:0]     RETRY_MAX    = RETRY_W'(MAX_RETRIES);
    localparam logic [TIMER_WIDTH-1:0] TIMEOUT_LAST = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [AXIS_DATA_WIDTH/8-1:0] TX_KEEP = 64'h0FFF_FFFF_FFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [31:0]            target_q, target_d;
    logic [RETRY_W-1:0]     retry_q, retry_d;
    logic [TIMER_WIDTH-1:0] timer_q, timer_d;
    logic                   sof_q, sof_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic                   rsp_fail_q, rsp_fail_d;
    logic [31:0]            rsp_ip_q, rsp_ip_d;
    logic [47:0]            rsp_mac_q, rsp_mac_d;

    logic [AXIS_DATA_WIDTH-1:0]  tx_frame;
    logic [AXIS_TUSER_WIDTH-1:0] tx_user;
    logic [15:0]                 rx_ethertype, rx_oper;
    logic [31:0]                 rx_spa, rx_tpa;
    logic [47:0]                 rx_sha;
    logic                        rx_match;
    logic                        unused_ok;

    // Receive field extraction; wire byte order is big-endian inside each field.
    assign rx_ethertype = {s_axis_tdata[8*12 +: 8], s_axis_tdata[8*13 +: 8]};
    assign rx_oper      = {s_axis_tdata[8*20 +: 8], s_axis_tdata[8*21 +: 8]};
    assign rx_sha       = {s_axis_tdata[8*22 +: 8], s_axis_tdata[8*23 +: 8],
                           s_axis_tdata[8*24 +: 8], s_axis_tdata[8*25 +: 8],
                           s_axis_tdata[8*26 +: 8], s_axis_tdata[8*27 +: 8]};
    assign rx_spa       = {s_axis_tdata[8*28 +: 8], s_axis_tdata[8*29 +: 8],
                           s_axis_tdata[8*30 +: 8], s_axis_tdata[8*31 +: 8]};
    assign rx_tpa       = {s_axis_tdata[8*38 +: 8], s_axis_tdata[8*39 +: 8],
                           s_axis_tdata[8*40 +: 8], s_axis_tdata[8*41 +: 8]};

    assign rx_match = s_axis_tvalid && sof_q &&
                      (rx_ethertype == 16'h0806) && (rx_oper == 16'h0002) &&
                      (rx_spa == target_q) && (rx_tpa == IP_ADDR);

    assign sof_d = s_axis_tvalid ? s_axis_tlast : sof_q;

    always_comb begin
        tx_frame = '0;
        for (int i = 0; i < 6; i++) begin
            tx_frame[8*i +: 8]      = 8'hFF;
            tx_frame[8*(6+i) +: 8]  = MAC_ADDR[8*(5-i) +: 8];
            tx_frame[8*(22+i) +: 8] = MAC_ADDR[8*(5-i) +: 8];
        end
        tx_frame[8*12 +: 8] = 8'h08;
        tx_frame[8*13 +: 8] = 8'h06;
        tx_frame[8*14 +: 8] = 8'h00;
        tx_frame[8*15 +: 8] = 8'h01;
        tx_frame[8*16 +: 8] = 8'h08;
        tx_frame[8*17 +: 8] = 8'h00;
        tx_frame[8*18 +: 8] = 8'h06;
        tx_frame[8*19 +: 8] = 8'h04;
        tx_frame[8*20 +: 8] = 8'h00;
        tx_frame[8*21 +: 8] = 8'h01;
        for (int i = 0; i < 4; i++) begin
            tx_frame[8*(28+i) +: 8] = IP_ADDR[8*(3-i) +: 8];
            tx_frame[8*(38+i) +: 8] = target_q[8*(3-i) +: 8];
        end
    end

    always_comb begin
        tx_user         = '0;
        tx_user[15:0]   = 16'd60;
        tx_user[31:24]  = DST_PORT;
    end

    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        retry_d     = retry_q;
        timer_d     = timer_q;
        rsp_valid_d = 1'b0;
        rsp_fail_d  = rsp_fail_q;
        rsp_ip_d    = rsp_ip_q;
        rsp_mac_d   = rsp_mac_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    target_d = req_ip;
                    retry_d  = '0;
                    state_d  = ST_SEND;
                end
            end
            ST_SEND: begin
                if (m_axis_tready) begin
                    timer_d = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                timer_d = timer_q + 1'b1;
                // A reply landing on the last timer cycle still counts as success.
                if (rx_match) begin
                    rsp_valid_d = 1'b1;
                    rsp_fail_d  = 1'b0;
                    rsp_ip_d    = target_q;
                    rsp_mac_d   = rx_sha;
                    state_d     = ST_IDLE;
                end else if (timer_q == TIMEOUT_LAST) begin
                    if (retry_q < RETRY_MAX) begin
                        retry_d = retry_q + 1'b1;
                        state_d = ST_SEND;
                    end else begin
                        rsp_valid_d = 1'b1;
                        rsp_fail_d  = 1'b1;
                        rsp_ip_d    = target_q;
                        rsp_mac_d   = '0;
                        state_d     = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge axis_aclk) begin
        if (axis_reset) begin
            state_q     <= ST_IDLE;
            target_q    <= '0;
            retry_q     <= '0;
            timer_q     <= '0;
            sof_q       <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_fail_q  <= 1'b0;
            rsp_ip_q    <= '0;
            rsp_mac_q   <= '0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            retry_q     <= retry_d;
            timer_q     <= timer_d;
            sof_q       <= sof_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_fail_q  <= rsp_fail_d;
            rsp_ip_q    <= rsp_ip_d;
            rsp_mac_q   <= rsp_mac_d;
        end
    end

    // Reset gates the handshake outputs combinationally so an in-flight frame drops at once.
    assign req_ready     = (state_q == ST_IDLE) && !axis_reset;
    assign m_axis_tvalid = (state_q == ST_SEND) && !axis_reset;
    assign m_axis_tdata  = m_axis_tvalid ? tx_frame : '0;
    assign m_axis_tkeep  = m_axis_tvalid ? TX_KEEP : '0;
    assign m_axis_tuser  = m_axis_tvalid ? tx_user : '0;
    assign m_axis_tlast  = m_axis_tvalid;
    assign s_axis_tready = 1'b1;

    assign rsp_valid = rsp_valid_q;
    assign rsp_fail  = rsp_fail_q;
    assign rsp_ip    = rsp_ip_q;
    assign rsp_mac   = rsp_mac_q;

    assign unused_ok = ^{s_axis_tkeep, s_axis_tuser, s_axis_tdata};

endmodule

// File: tb/tb_arp_request_gen.sv
// Bench for arp_request_gen: table vectors, reset sequences and randomized requests
// checked against a frame-level model and an expected-result queue.
module tb_arp_request_gen;

    localparam int T    = 100;
    localparam int MAXR = 2;
    localparam logic [47:0] MY_MAC = 48'hDA_02_03_04_05_00;
    localparam logic [31:0] MY_IP  = 32'hC0_A8_01_0A;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [31:0]  req_ip = '0;
    logic         rsp_valid, rsp_fail;
    logic [31:0]  rsp_ip;
    logic [47:0]  rsp_mac;
    logic [511:0] m_axis_tdata;
    logic [63:0]  m_axis_tkeep;
    logic [255:0] m_axis_tuser;
    logic         m_axis_tvalid, m_axis_tlast;
    logic         m_axis_tready = 1'b0;
    logic [511:0] s_axis_tdata = '0;
    logic [63:0]  s_axis_tkeep = '0;
    logic [255:0] s_axis_tuser = '0;
    logic         s_axis_tvalid = 1'b0;
    logic         s_axis_tlast = 1'b0;
    logic         s_axis_tready;

    arp_request_gen #(
        .TIMEOUT_CYCLES(T),
        .MAX_RETRIES   (MAXR),
        .TIMER_WIDTH   (24)
    ) dut (
        .axis_aclk(clk), .axis_reset(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_ip(req_ip),
        .rsp_valid(rsp_valid), .rsp_fail(rsp_fail), .rsp_ip(rsp_ip), .rsp_mac(rsp_mac),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tuser(s_axis_tuser),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast)
    );

    // Clock and step helper: inputs change and outputs are sampled 1 time unit after the edge.
    always #5 clk = ~clk;

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int vectors = 0;
    int miscompares = 0;
    logic [80:0] exp_q[$];

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: frames and results computed from the byte-level frame description.
    function automatic logic [511:0] pack_bytes(input logic [7:0] b[64]);
        logic [511:0] f;
        for (int i = 0; i < 64; i++) f[8*i +: 8] = b[i];
        return f;
    endfunction

    function automatic logic [511:0] exp_frame(input logic [31:0] tip);
        logic [7:0] b[64];
        logic [7:0] hdr[10];
        hdr = '{8'h08, 8'h06, 8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h01};
        for (int i = 0; i < 64; i++) b[i] = 8'h00;
        for (int i = 0; i < 6; i++) begin
            b[i]      = 8'hFF;
            b[6 + i]  = MY_MAC[47 - 8*i -: 8];
            b[22 + i] = MY_MAC[47 - 8*i -: 8];
        end
        for (int i = 0; i < 10; i++) b[12 + i] = hdr[i];
        for (int i = 0; i < 4; i++) begin
            b[28 + i] = MY_IP[31 - 8*i -: 8];
            b[38 + i] = tip[31 - 8*i -: 8];
        end
        return pack_bytes(b);
    endfunction

    function automatic logic [255:0] exp_user();
        logic [255:0] u = '0;
        u[15:0]  = 16'd60;
        u[31:24] = 8'h01;
        return u;
    endfunction

    function automatic logic [47:0] mac_for(input logic [31:0] tip);
        return {40'hDA_02_03_04_05, tip[7:0] - 8'h0A};
    endfunction

    function automatic logic [511:0] arp_frame(input logic [15:0] etype, input logic [15:0] oper,
                                               input logic [47:0] sha, input logic [31:0] spa,
                                               input logic [31:0] tpa);
        logic [7:0] b[64];
        for (int i = 0; i < 64; i++) b[i] = 8'($urandom);
        b[12] = etype[15:8];
        b[13] = etype[7:0];
        b[20] = oper[15:8];
        b[21] = oper[7:0];
        for (int i = 0; i < 6; i++) b[22 + i] = sha[47 - 8*i -: 8];
        for (int i = 0; i < 4; i++) begin
            b[28 + i] = spa[31 - 8*i -: 8];
            b[38 + i] = tpa[31 - 8*i -: 8];
        end
        return pack_bytes(b);
    endfunction

    function automatic logic [511:0] good_reply(input logic [31:0] tip);
        return arp_frame(16'h0806, 16'h0002, mac_for(tip), tip, MY_IP);
    endfunction

    // Near-miss replies: 1 wrong SPA, 2 request opcode, 3 wrong TPA, 4 wrong ethertype.
    function automatic logic [511:0] bad_reply(input logic [31:0] tip, input int kind);
        case (kind)
            1:       return arp_frame(16'h0806, 16'h0002, mac_for(tip), tip + 32'd1, MY_IP);
            2:       return arp_frame(16'h0806, 16'h0001, mac_for(tip), tip, MY_IP);
            3:       return arp_frame(16'h0806, 16'h0002, mac_for(tip), tip, MY_IP ^ 32'd1);
            default: return arp_frame(16'h0800, 16'h0002, mac_for(tip), tip, MY_IP);
        endcase
    endfunction

    // Driver tasks for the receive port.
    task automatic idle_rx();
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tdata  = {16{$urandom}};
    endtask

    task automatic drive_beat(input logic [511:0] d, input logic last);
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = last;
        s_axis_tdata  = d;
        s_axis_tkeep  = {2{$urandom}};
        s_axis_tuser  = {8{$urandom}};
    endtask

    // Scoreboard: every result pulse must match the next expected {fail, ip, mac}.
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", {rsp_fail, rsp_ip, rsp_mac}, '0);
            end else begin
                chk("rsp_result", {rsp_fail, rsp_ip, rsp_mac}, exp_q.pop_front());
            end
        end
    end

    // One request: ans = attempt that gets the good reply at timer value k (-1: never).
    task automatic do_req(input logic [31:0] tip, input int ans, input int k, input int bad,
                          input int stall, input int multi, input logic exp_fail,
                          input logic [47:0] exp_mac);
        logic [511:0] d0;
        logic [255:0] u0;
        logic [63:0]  kp0;
        bit done = 1'b0;
        exp_q.push_back({exp_fail, tip, exp_mac});
        chk("req_ready_idle", req_ready, 1);
        req_valid = 1'b1;
        req_ip    = tip;
        step();
        req_valid = 1'b0;
        req_ip    = $urandom;
        chk("req_ready_busy", req_ready, 0);
        for (int a = 0; a <= MAXR && !done; a++) begin
            chk("tx_tvalid", m_axis_tvalid, 1);
            chk("tx_tdata", m_axis_tdata, exp_frame(tip));
            chk("tx_tkeep", m_axis_tkeep, 64'h0FFF_FFFF_FFFF_FFFF);
            chk("tx_tuser", m_axis_tuser, exp_user());
            chk("tx_tlast", m_axis_tlast, 1);
            d0 = m_axis_tdata; kp0 = m_axis_tkeep; u0 = m_axis_tuser;
            for (int s = 0; s < stall; s++) begin
                if (s == 0) drive_beat(good_reply(tip), 1'b1);
                step();
                idle_rx();
                chk("stall_tvalid", m_axis_tvalid, 1);
                chk("stall_tdata", m_axis_tdata, d0);
                chk("stall_tkeep", m_axis_tkeep, kp0);
                chk("stall_tuser", m_axis_tuser, u0);
                chk("stall_tlast", m_axis_tlast, 1);
                chk("stall_rsp_quiet", rsp_valid, 0);
            end
            m_axis_tready = 1'b1;
            step();
            m_axis_tready = 1'b0;
            chk("tx_single_beat", m_axis_tvalid, 0);
            for (int j = 0; j < T && !done; j++) begin
                idle_rx();
                if (bad != 0 && j == 1) drive_beat(bad_reply(tip, bad), 1'b1);
                if (a == ans && multi != 0 && j == k - 3) drive_beat({16{$urandom}}, 1'b0);
                if (a == ans && multi != 0 && j == k - 2) drive_beat(good_reply(tip), 1'b1);
                if (a == ans && j == k) drive_beat(good_reply(tip), 1'b1);
                chk("rsp_quiet", rsp_valid, 0);
                step();
                if (a == ans && j == k) begin
                    chk("rsp_on_match", rsp_valid, 1);
                    chk("rsp_match_ok", rsp_fail, 0);
                    done = 1'b1;
                end
            end
            idle_rx();
        end
        if (!done) begin
            chk("rsp_on_timeout", rsp_valid, 1);
            chk("rsp_timeout_fail", rsp_fail, 1);
        end
        chk("no_retransmit", m_axis_tvalid, 0);
        step();
        chk("rsp_one_cycle", rsp_valid, 0);
        chk("req_ready_after", req_ready, 1);
        chk("still_no_tx", m_axis_tvalid, 0);
    endtask

    typedef struct {
        logic [31:0] ip;
        int          ans;
        int          k;
        int          bad;
        int          stall;
        int          multi;
        logic        exp_fail;
        logic [47:0] exp_mac;
    } vec_t;

    vec_t vecs[9];

    initial begin : watchdog
        #(2_000_000);
        miscompares++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        vecs[0] = '{32'hC0A8010B,  0,    5, 0,  0, 0, 1'b0, 48'hDA0203040501};
        vecs[1] = '{32'hC0A8010B, -1,    5, 0,  0, 0, 1'b1, 48'h0};
        vecs[2] = '{32'hC0A8010B, -1,    5, 1,  0, 0, 1'b1, 48'h0};
        vecs[3] = '{32'hC0A8010B, -1,    5, 2,  0, 0, 1'b1, 48'h0};
        vecs[4] = '{32'hC0A8010B, -1,    5, 3,  0, 0, 1'b1, 48'h0};
        vecs[5] = '{32'hC0A8010C,  0,    7, 4, 10, 0, 1'b0, 48'hDA0203040502};
        vecs[6] = '{32'hC0A8010E,  0, T - 1, 0,  0, 0, 1'b0, 48'hDA0203040504};
        vecs[7] = '{32'hC0A8010F,  2,   10, 1,  2, 0, 1'b0, 48'hDA0203040505};
        vecs[8] = '{32'hC0A80110,  1,   20, 0,  0, 1, 1'b0, 48'hDA0203040506};

        // Reset state.
        idle_rx();
        step(2);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_s_tready", s_axis_tready, 1);
        chk("rst_tdata", m_axis_tdata, 0);
        rst = 1'b0;
        step();
        chk("post_rst_req_ready", req_ready, 1);
        chk("post_rst_rsp", {rsp_valid, rsp_fail, rsp_ip, rsp_mac}, 0);
        chk("post_rst_tx", {m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tuser}, 0);

        foreach (vecs[i])
            do_req(vecs[i].ip, vecs[i].ans, vecs[i].k, vecs[i].bad, vecs[i].stall,
                   vecs[i].multi, vecs[i].exp_fail, vecs[i].exp_mac);

        // Reset while a frame is offered: tvalid must drop in the same cycle.
        req_valid = 1'b1; req_ip = 32'hC0A8010B;
        step();
        req_valid = 1'b0;
        chk("send_before_rst", m_axis_tvalid, 1);
        rst = 1'b1;
        #1;
        chk("send_rst_drop", m_axis_tvalid, 0);
        step();
        rst = 1'b0;
        step();
        chk("send_rst_idle", req_ready, 1);
        chk("send_rst_no_tx", m_axis_tvalid, 0);

        // Reset during WAIT: no stale result, then a fresh request resolves.
        req_valid = 1'b1; req_ip = 32'hC0A8010B;
        step();
        req_valid = 1'b0;
        m_axis_tready = 1'b1;
        step();
        m_axis_tready = 1'b0;
        step(20);
        drive_beat(good_reply(32'hC0A8010B), 1'b1);
        rst = 1'b1;
        step();
        idle_rx();
        rst = 1'b0;
        for (int i = 0; i < T + 10; i++) begin
            chk("wait_rst_quiet", {rsp_valid, m_axis_tvalid}, 0);
            step();
        end
        do_req(32'hC0A8010D, 0, 9, 0, 0, 0, 1'b0, 48'hDA0203040503);

        // Randomized requests checked against the model.
        for (int n = 0; n < 6; n++) begin
            logic [31:0] rip;
            int rans;
            rip  = {24'hC0A801, 8'($urandom_range(11, 250))};
            rans = $urandom_range(0, MAXR + 1);
            if (rans == MAXR + 1) rans = -1;
            do_req(rip, rans, $urandom_range(5, T - 1), $urandom_range(0, 4),
                   $urandom_range(0, 3), $urandom_range(0, 1), rans < 0,
                   (rans < 0) ? 48'h0 : mac_for(rip));
        end

        step(2);
        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
